mealy_seq_checker: RTL and testbench

- Receive-side companion to the team's 4-state Mealy sequence generator.
- Consumes the generator's 3-bit symbol stream and tracks its phase, checking two legal frames:
  - short: 001,010,100 (flag=1 path)
  - long: 001,010,011,100 (flag=0 path)
- Acquires lock after a run of good frames, flags protocol violations and counts frames and errors.
- Sits directly on the generator's output bus in the FSM sandbox bench or on-chip.

---
 rtl/fsm_seq_pkg.sv | 23 ++
 rtl/sat_counter.sv | 24 ++
 rtl/mealy_seq_checker.sv | 132 +++++++++++++
 tb/tb_mealy_seq_checker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the 4-state Mealy sequence generator and its
// receive-side checker: the four legal symbols, the frame phase encoding
// and the checker's lock states.
package fsm_seq_pkg;

    localparam logic [2:0] SYM_A = 3'b001;
    localparam logic [2:0] SYM_B = 3'b010;
    localparam logic [2:0] SYM_C = 3'b011;
    localparam logic [2:0] SYM_D = 3'b100;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_S1   = 2'd1,
        P_S2   = 2'd2,
        P_S3   = 2'd3
    } phase_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears count
//   inc   - add one this cycle (ignored once saturated)
//   count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mealy_seq_checker.sv
// Receive-side checker for the Mealy sequence generator. Follows the frame
// phase of the incoming symbol stream (short 001,010,100 / long
// 001,010,011,100), acquires lock after SYNC_FRAMES consecutive good frames,
// and flags and counts violations while locked.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   sym_valid  - sym is consumed only when high
//   sym        - received 3-bit symbol
//   locked     - checker is in the LOCKED state
//   frame_done - one-cycle pulse when a well-formed frame completes
//   frame_long - qualifies frame_done: 1 = long frame, 0 = short frame
//   err        - one-cycle pulse on a violation while locked
//   frame_cnt  - saturating count of well-formed frames
//   err_cnt    - saturating count of violations seen while locked
module mealy_seq_checker
    import fsm_seq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [2:0]       sym,
    output logic             locked,
    output logic             frame_done,
    output logic             frame_long,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] SYNC_L = 4'(SYNC_FRAMES);

    phase_t     phase, phase_n;
    lock_t      lock, lock_n;
    logic [3:0] streak, streak_n;
    logic       complete, is_long, viol, err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= P_IDLE;
            lock       <= HUNT;
            streak     <= '0;
            frame_done <= 1'b0;
            frame_long <= 1'b0;
            err        <= 1'b0;
        end else begin
            phase      <= phase_n;
            lock       <= lock_n;
            streak     <= streak_n;
            frame_done <= complete;
            frame_long <= complete & is_long;
            err        <= err_n;
        end
    end

    assign locked = (lock == LOCKED);

    // Each valid symbol is classified exactly once: advance, complete, or
    // violate. That is what keeps frame_done and err mutually exclusive.
    always_comb begin
        phase_n  = phase;
        lock_n   = lock;
        streak_n = streak;
        complete = 1'b0;
        is_long  = 1'b0;
        viol     = 1'b0;
        err_n    = 1'b0;

        if (sym_valid) begin
            case (phase)
                P_IDLE: if (sym == SYM_A) phase_n = P_S1; else viol = 1'b1;
                P_S1:   if (sym == SYM_B) phase_n = P_S2; else viol = 1'b1;
                P_S2: begin
                    if (sym == SYM_C) begin
                        phase_n = P_S3;
                    end else if (sym == SYM_D) begin
                        phase_n  = P_IDLE;
                        complete = 1'b1;
                    end else begin
                        viol = 1'b1;
                    end
                end
                P_S3: begin
                    if (sym == SYM_D) begin
                        phase_n  = P_IDLE;
                        complete = 1'b1;
                        is_long  = 1'b1;
                    end else begin
                        viol = 1'b1;
                    end
                end
                default: viol = 1'b1;
            endcase

            if (viol) begin
                // A stray 001 is taken as the start of a fresh frame so the
                // checker resyncs without losing the frame it begins.
                phase_n  = (sym == SYM_A) ? P_S1 : P_IDLE;
                streak_n = '0;
                if (lock == LOCKED) begin
                    lock_n = HUNT;
                    err_n  = 1'b1;
                end
            end

            if (complete) begin
                streak_n = (streak >= SYNC_L) ? SYNC_L : streak + 4'd1;
                if ((lock == HUNT) && (streak_n == SYNC_L)) begin
                    lock_n = LOCKED;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (complete),
        .count (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_n),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_mealy_seq_checker.sv
// Directed bench for mealy_seq_checker. Two instances share the stimulus:
// dut uses the default 16-bit counters, dut_s uses 2-bit counters so that
// saturation can be reached quickly.
module tb_mealy_seq_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sym_valid = 1'b0;
    logic [2:0]  sym = 3'b000;

    logic        locked, frame_done, frame_long, err;
    logic [15:0] frame_cnt, err_cnt;

    logic        locked_s, frame_done_s, frame_long_s, err_s;
    logic [1:0]  frame_cnt_s, err_cnt_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mealy_seq_checker #(.CNT_W(16), .SYNC_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .locked     (locked),
        .frame_done (frame_done),
        .frame_long (frame_long),
        .err        (err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    mealy_seq_checker #(.CNT_W(2), .SYNC_FRAMES(2)) dut_s (
        .clk        (clk),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .locked     (locked_s),
        .frame_done (frame_done_s),
        .frame_long (frame_long_s),
        .err        (err_s),
        .frame_cnt  (frame_cnt_s),
        .err_cnt    (err_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one symbol for one clock; outputs are sampled 1 ns after the edge.
    task automatic send(input logic v, input logic [2:0] s);
        sym_valid = v;
        sym       = s;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sym_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fd"},     frame_done, 0);
        chk({tag, "_fl"},     frame_long, 0);
        chk({tag, "_err"},    err, 0);
        chk({tag, "_fcnt"},   frame_cnt, 0);
        chk({tag, "_ecnt"},   err_cnt, 0);
    endtask

    task automatic short_frame();
        send(1, 3'b001);
        send(1, 3'b010);
        send(1, 3'b100);
    endtask

    initial begin
        int ek, fk;

        // Test 1: acquire lock
        do_reset();
        chk_all_zero("rst1");
        send(1, 3'b001); chk("t1_fd_a", frame_done, 0);
        send(1, 3'b010); chk("t1_fd_b", frame_done, 0);
        send(1, 3'b100);
        chk("t1_fd1", frame_done, 1);
        chk("t1_fl1", frame_long, 0);
        chk("t1_lock1", locked, 0);
        chk("t1_fcnt1", frame_cnt, 1);
        send(1, 3'b001); chk("t1_fd_pulse", frame_done, 0);
        send(1, 3'b010);
        send(1, 3'b011); chk("t1_fd_c", frame_done, 0);
        send(1, 3'b100);
        chk("t1_fd2", frame_done, 1);
        chk("t1_fl2", frame_long, 1);
        chk("t1_lock2", locked, 1);
        chk("t1_fcnt2", frame_cnt, 2);
        chk("t1_ecnt", err_cnt, 0);
        chk("t1_err", err, 0);

        // Test 2: violation while locked, then re-lock
        send(1, 3'b001); chk("t2_err_a", err, 0);
        send(1, 3'b011);
        chk("t2_err", err, 1);
        chk("t2_ecnt", err_cnt, 1);
        chk("t2_lock", locked, 0);
        chk("t2_fd", frame_done, 0);
        send(1, 3'b001); chk("t2_err_clr", err, 0);
        send(1, 3'b010);
        send(1, 3'b100); chk("t2_fd1", frame_done, 1);
        chk("t2_lock_mid", locked, 0);
        short_frame();
        chk("t2_relock", locked, 1);
        chk("t2_fcnt", frame_cnt, 4);
        chk("t2_ecnt2", err_cnt, 1);

        // Test 3: resync on 001
        send(1, 3'b001);
        send(1, 3'b010);
        send(1, 3'b001);
        chk("t3_err", err, 1);
        chk("t3_ecnt", err_cnt, 2);
        chk("t3_lock", locked, 0);
        send(1, 3'b010); chk("t3_err_clr", err, 0);
        send(1, 3'b100);
        chk("t3_fd", frame_done, 1);
        chk("t3_fl", frame_long, 0);
        chk("t3_fcnt", frame_cnt, 5);

        // Test 4: noise while hunting
        do_reset();
        chk_all_zero("rst4");
        send(1, 3'b111); chk("t4_err_a", err, 0);
        send(1, 3'b000); chk("t4_err_b", err, 0);
        send(1, 3'b010); chk("t4_err_c", err, 0);
        short_frame();
        chk("t4_fd", frame_done, 1);
        chk("t4_fcnt", frame_cnt, 1);
        chk("t4_ecnt", err_cnt, 0);
        chk("t4_lock", locked, 0);

        // Test 5A: valid gaps mid-frame
        send(1, 3'b001);
        for (int i = 0; i < 3; i++) begin
            send(0, 3'b111);
            chk("t5_idle_fd", frame_done, 0);
            chk("t5_idle_err", err, 0);
        end
        send(1, 3'b010);
        send(1, 3'b100);
        chk("t5_fd", frame_done, 1);
        chk("t5_fcnt", frame_cnt, 2);
        chk("t5_lock", locked, 1);

        // Test 5B: reset mid-frame discards the partial frame
        send(1, 3'b001);
        send(1, 3'b010);
        do_reset();
        chk_all_zero("rst5");
        send(1, 3'b100);
        chk("t5b_fd", frame_done, 0);
        chk("t5b_err", err, 0);
        chk("t5b_ecnt", err_cnt, 0);

        // Test 6: saturation on the 2-bit instance
        do_reset();
        chk("t6_rst_f", frame_cnt_s, 0);
        chk("t6_rst_e", err_cnt_s, 0);
        short_frame();
        short_frame();
        chk("t6_lock", locked_s, 1);
        chk("t6_f0", frame_cnt_s, 2);
        for (int k = 1; k <= 4; k++) begin
            send(1, 3'b111);
            chk("t6_err", err_s, 1);
            ek = (k > 3) ? 3 : k;
            chk("t6_ecnt", err_cnt_s, ek);
            short_frame();
            short_frame();
            chk("t6_relock", locked_s, 1);
            fk = (2 + 2 * k > 3) ? 3 : 2 + 2 * k;
            chk("t6_fcnt", frame_cnt_s, fk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
